priority_arbiter_ctrl: RTL
==========================

Name: priority_arbiter_ctrl

Overview:
Sequential arbiter that shares one downstream resource among 8 requesters. Each arbitration picks one winner by fixed priority (highest index wins) or by rotating round-robin priority, and presents it as a one-hot grant plus a 3-bit encoded index. A grant is held until its requester drops its request or a hold-time limit expires. The block sits in front of any shared datapath that needs one-at-a-time access.

Parameters:
NREQ, 8, number of requesters; fixed at 8, with a 3-bit index.
MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 disables the limit; legal range 0..255.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
req  input  8  request vector; bit i is requester i.
mode  input  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration.
gnt  output  8  one-hot grant, registered; all zero when no grant is active.
gnt_idx  output  3  encoded index of the granted requester; 0 when no grant is active.
gnt_valid  output  1  high while a grant is active; equals |gnt.
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, hold_cnt=0, rr_ptr=7. Reset mid-grant drops gnt immediately, with no RELEASE cycle.
- All outputs are registered; there is no combinational path from req to any output.
- States:
  - IDLE
  - GRANT
  - RELEASE
- Arbitration happens at a rising edge in IDLE or RELEASE when req!=0.
  - Fixed mode: candidate order is 7,6,...,0.
  - RR mode: candidate order is rr_ptr, rr_ptr-1, ..., wrapping mod 8.
  - The first candidate with req set wins. The winner is loaded into gnt, gnt_idx and gnt_valid at that same edge, and the state moves to GRANT with hold_cnt=0.
- Latency: a req asserted before edge k, with the FSM in IDLE, gives gnt visible from edge k.
- IDLE with req==0: stay in IDLE, outputs zero.
- GRANT, each edge:
  - If req[gnt_idx]==0: go to RELEASE (normal release).
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: go to RELEASE and pulse timeout=1 for the cycle that RELEASE is active.
  - Else: hold_cnt+1 and the grant is unchanged.
  - Requests from other requesters are ignored while a grant is held; there is no preemption, even by a higher index.
- Entering RELEASE clears gnt, gnt_idx and gnt_valid. This gives exactly one dead cycle between grants (bus turnaround).
- rr_ptr update: on entry to RELEASE, rr_ptr <= (gnt_idx-1) mod 8 in both modes, so the last winner becomes lowest priority. Wrap cases: idx 0 gives ptr 7; idx 7 gives ptr 6. rr_ptr is used only when mode=1.
- RELEASE, next edge: arbitrate as above if req!=0 (go to GRANT); otherwise go to IDLE.
- A requester revoked by timeout may re-win at the next arbitration if it still has the highest priority. In fixed mode this means a hog is re-granted after one dead cycle. This is intended.
- mode changes take effect only at the next arbitration edge and never alter a held grant.
- hold_cnt width is 8 bits. When MAX_HOLD=0, hold_cnt saturates at 255 and never triggers a release.
- Invariants: gnt is always zero or one-hot; gnt_valid==|gnt; whenever gnt_valid=1, gnt==(1<<gnt_idx).
- X on req is not handled specially; the bench drives only known values.

Test Plan:
1. Reset, then req=8'b0000_0000 for 5 cycles -> gnt=0, gnt_idx=0, gnt_valid=0, timeout=0 throughout.
2. Fixed mode, req=8'b0010_0110 -> gnt=8'b0010_0000 and gnt_idx=5 one edge later. Drop bit 5 -> one cycle of gnt=0, then gnt=8'b0000_0100, gnt_idx=2.
3. RR mode, req=8'hFF held, with each requester dropping its req 2 cycles after being granted and re-raising it the following cycle -> grant order is 7,6,5,...,0,7, with one dead cycle between grants; check rr_ptr wraps from 7 to 6 and from 0 to 7.
4. MAX_HOLD=4, fixed mode, req=8'b1000_0001 held constant -> gnt_idx=7 for exactly 4 cycles, then timeout=1 and gnt=0 for one cycle, then gnt_idx=7 again. Repeat in RR mode -> second grant goes to index 0.
5. While in GRANT with gnt_idx=3 and req=8'b1000_1000, raise bit 7 -> no preemption; gnt stays 8'b0000_1000 until bit 3 drops.
6. Assert rst asynchronously (between clock edges) mid-GRANT with gnt_idx=4 -> gnt, gnt_idx and gnt_valid go to 0 immediately. After rst is released with req=8'b0001_0000 -> gnt_idx=4 at the first edge, and rr_ptr is back to 7.

Source files
------------

// File: rtl/priority_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// priority_arbiter_ctrl
//
// Shares one downstream resource among 8 requesters. At each arbitration the
// winner is chosen either by fixed priority (index 7 highest) or by a rotating
// round-robin pointer. The winner is presented as a one-hot grant and a 3-bit
// index. The grant is kept until the owner drops its request or until it has
// been held MAX_HOLD cycles. Every grant is followed by exactly one dead cycle
// (RELEASE) before the next grant, giving the downstream bus a turnaround slot.
//
// Parameters:
//   NREQ      number of requesters (fixed at 8, 3-bit index)
//   MAX_HOLD  maximum consecutive cycles for one grant, 0 = unlimited (0..255)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   req        request vector, bit i belongs to requester i
//   mode       0 = fixed priority, 1 = round-robin (sampled at arbitration)
//   gnt        registered one-hot grant, zero when no grant is active
//   gnt_idx    registered index of the granted requester, zero when idle
//   gnt_valid  high while a grant is active (equals |gnt)
//   timeout    one-cycle pulse while RELEASE follows a hold-limit revocation
// ---------------------------------------------------------------------------
module priority_arbiter_ctrl #(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            mode,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // The hold limit compares against the last legal count value, so a grant
  // taken with hold_cnt = 0 is visible for exactly MAX_HOLD cycles.
  localparam logic       HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [2:0]      gnt_idx_n;
  logic            gnt_valid_n;
  logic            timeout_n;
  logic [7:0]      hold_cnt, hold_cnt_n;
  logic [2:0]      rr_ptr, rr_ptr_n;

  logic [2:0]      start_ptr;
  logic [2:0]      cand;
  logic [2:0]      win_idx;
  logic            win_found;

  // Winner selection. Fixed priority is the round-robin search started from
  // index 7, so both modes share one descending, wrapping scan.
  always_comb begin
    start_ptr = mode ? rr_ptr : 3'd7;
    cand      = 3'd0;
    win_idx   = 3'd0;
    win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = start_ptr - 3'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic. All outputs are computed here and
  // registered below, so nothing in req reaches an output combinationally.
  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    timeout_n   = 1'b0;
    hold_cnt_n  = hold_cnt;
    rr_ptr_n    = rr_ptr;

    case (state)
      IDLE, RELEASE: begin
        gnt_n       = '0;
        gnt_idx_n   = 3'd0;
        gnt_valid_n = 1'b0;
        hold_cnt_n  = 8'd0;
        if (win_found) begin
          state_n     = GRANT;
          gnt_n       = NREQ'(1) << win_idx;
          gnt_idx_n   = win_idx;
          gnt_valid_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end

      GRANT: begin
        if (!req[gnt_idx] || (HOLD_EN && (hold_cnt == HOLD_LAST))) begin
          // The last owner becomes lowest priority for round-robin.
          state_n     = RELEASE;
          gnt_n       = '0;
          gnt_idx_n   = 3'd0;
          gnt_valid_n = 1'b0;
          hold_cnt_n  = 8'd0;
          rr_ptr_n    = gnt_idx - 3'd1;
          timeout_n   = req[gnt_idx];
        end else begin
          // Saturation only matters with the limit disabled.
          hold_cnt_n = (hold_cnt == 8'd255) ? hold_cnt : hold_cnt + 8'd1;
        end
      end

      default: begin
        state_n     = IDLE;
        gnt_n       = '0;
        gnt_idx_n   = 3'd0;
        gnt_valid_n = 1'b0;
        hold_cnt_n  = 8'd0;
      end
    endcase
  end

  // State and output registers. Reset drops a live grant immediately,
  // without passing through RELEASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= 8'd0;
      rr_ptr    <= 3'd7;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
      timeout   <= timeout_n;
      hold_cnt  <= hold_cnt_n;
      rr_ptr    <= rr_ptr_n;
    end
  end

endmodule
